// File: rtl/cpu_exec_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// cpu_exec_sequencer : multi-cycle control FSM for fetch/decode/execute/mem/wb
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
module cpu_exec_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  ins,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        div_done,
  input  logic        teq_eq,
  output logic        pc_we,
  output logic        ir_we,
  output logic        reg_we,
  output logic        hilo_we,
  output logic        dmem_re,
  output logic        dmem_we,
  output logic        div_start,
  output logic        cp0_exc,
  output logic        cp0_eret,
  output logic [4:0]  cause,
  output logic [2:0]  state,
  output logic [31:0] retired
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_DIVW   = 3'd5;
  localparam logic [2:0] S_EXC    = 3'd6;

  localparam logic [4:0] C_SYS = 5'd8;
  localparam logic [4:0] C_BP  = 5'd9;
  localparam logic [4:0] C_RI  = 5'd10;
  localparam logic [4:0] C_TR  = 5'd13;

  logic [2:0]  r_state;
  logic [5:0]  r_op;
  logic [4:0]  r_cause;
  logic [31:0] r_retired;

  logic [2:0]  w_next_state;
  logic [4:0]  w_cause;
  logic        w_is_load;
  logic        w_is_store;
  logic        w_pc_we, w_ir_we, w_reg_we, w_hilo_we;
  logic        w_dmem_re, w_dmem_we, w_div_start, w_cp0_exc, w_cp0_eret;

  assign w_is_load  = (r_op >= 6'd35) && (r_op <= 6'd39);
  assign w_is_store = (r_op >= 6'd40) && (r_op <= 6'd42);

  always_comb begin
    w_next_state = r_state;
    w_cause      = 5'd0;
    w_pc_we      = 1'b0;
    w_ir_we      = 1'b0;
    w_reg_we     = 1'b0;
    w_hilo_we    = 1'b0;
    w_dmem_re    = 1'b0;
    w_dmem_we    = 1'b0;
    w_div_start  = 1'b0;
    w_cp0_exc    = 1'b0;
    w_cp0_eret   = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (imem_ready) begin
          w_ir_we      = 1'b1;
          w_next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        // An X on ins fails this compare and falls into the reserved-instruction path
        if (ins <= 6'd53) begin
          case (ins)
            6'd50: begin w_next_state = S_EXC; w_cause = C_BP;  end
            6'd51: begin w_next_state = S_EXC; w_cause = C_SYS; end
            6'd52: begin
              w_cp0_eret   = 1'b1;
              w_pc_we      = 1'b1;
              w_next_state = S_FETCH;
            end
            6'd53: begin
              if (teq_eq) begin
                w_next_state = S_EXC;
                w_cause      = C_TR;
              end else begin
                w_pc_we      = 1'b1;
                w_next_state = S_FETCH;
              end
            end
            6'd27, 6'd28: begin
              w_div_start  = 1'b1;
              w_next_state = S_DIVW;
            end
            default: w_next_state = S_EXEC;
          endcase
        end else begin
          w_next_state = S_EXC;
          w_cause      = C_RI;
        end
      end
      S_EXEC: begin
        if (w_is_load || w_is_store) begin
          w_next_state = S_MEM;
        end else begin
          case (r_op)
            6'd16, 6'd43, 6'd44, 6'd45, 6'd48: begin
              w_pc_we      = 1'b1;
              w_next_state = S_FETCH;
            end
            6'd20, 6'd21, 6'd26: begin
              w_hilo_we    = 1'b1;
              w_pc_we      = 1'b1;
              w_next_state = S_FETCH;
            end
            default: w_next_state = S_WB;
          endcase
        end
      end
      S_MEM: begin
        w_dmem_re = w_is_load;
        w_dmem_we = w_is_store;
        if (dmem_ready) begin
          if (w_is_load) begin
            w_next_state = S_WB;
          end else begin
            w_pc_we      = 1'b1;
            w_next_state = S_FETCH;
          end
        end
      end
      S_WB: begin
        w_reg_we     = 1'b1;
        w_pc_we      = 1'b1;
        w_next_state = S_FETCH;
      end
      S_DIVW: begin
        if (div_done) begin
          w_hilo_we    = 1'b1;
          w_pc_we      = 1'b1;
          w_next_state = S_FETCH;
        end
      end
      S_EXC: begin
        w_cp0_exc    = 1'b1;
        w_pc_we      = 1'b1;
        w_next_state = S_FETCH;
      end
      default: w_next_state = S_FETCH;
    endcase
  end

  // Reset masks the strobes combinationally so nothing fires before the first edge
  assign pc_we     = w_pc_we     & ~rst;
  assign ir_we     = w_ir_we     & ~rst;
  assign reg_we    = w_reg_we    & ~rst;
  assign hilo_we   = w_hilo_we   & ~rst;
  assign dmem_re   = w_dmem_re   & ~rst;
  assign dmem_we   = w_dmem_we   & ~rst;
  assign div_start = w_div_start & ~rst;
  assign cp0_exc   = w_cp0_exc   & ~rst;
  assign cp0_eret  = w_cp0_eret  & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_op      <= 6'd0;
      r_cause   <= 5'd0;
      r_retired <= 32'd0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_DECODE) begin
        r_op    <= ins;
        r_cause <= w_cause;
      end
      if (w_pc_we && (r_state != S_EXC)) begin
        r_retired <= r_retired + 32'd1;
      end
    end
  end

  assign cause   = r_cause;
  assign state   = r_state;
  assign retired = r_retired;

endmodule
`default_nettype wire

// File: doc/cpu_exec_sequencer.md
CPU_EXEC_SEQUENCER -- requirements
Module: cpu_exec_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, single rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1; reset is asynchronous and active-high; one clock.
REQ-003 SHALL have port ins, input, 6, decoded instruction index 0..53 from the instruction decoder; any other value, X included, is illegal.
REQ-004 SHALL have port imem_ready, input, 1, instruction word valid this cycle.
REQ-005 SHALL have port dmem_ready, input, 1, data memory access completes this cycle.
REQ-006 SHALL have port div_done, input, 1, divider result valid; single-cycle pulse.
REQ-007 SHALL have port teq_eq, input, 1, rs==rt compare result.
REQ-008 SHALL have outputs pc_we, ir_we, reg_we, hilo_we, dmem_re, dmem_we, div_start, cp0_exc and cp0_eret; each is 1 bit and is a control strobe.
REQ-009 SHALL have port cause, output, 5, exception code; valid only while cp0_exc=1.
REQ-010 SHALL have port state, output, 3, current FSM state for debug.
REQ-011 SHALL have port retired, output, 32, count of retired instructions.

Function
REQ-012 SHALL implement the states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, DIVW=5 and EXC=6; code 7 is unreachable and SHALL recover to FETCH.
REQ-013 FETCH SHALL hold until imem_ready=1; in that cycle it SHALL assert ir_we and go to DECODE.
REQ-014 DECODE SHALL latch ins into internal register op; all later states SHALL use op, not ins.
REQ-015 DECODE with ins>53 or ins=X SHALL go to EXC with cause=10 (RI).
REQ-016 DECODE with ins=50 (break) SHALL go to EXC with cause=9; with ins=51 (syscall) SHALL go to EXC with cause=8.
REQ-017 DECODE with ins=53 (teq) SHALL go to EXC with cause=13 if teq_eq=1; otherwise it SHALL assert pc_we and go to FETCH.
REQ-018 DECODE with ins=52 (eret) SHALL assert cp0_eret and pc_we and go to FETCH.
REQ-019 DECODE with ins=27 or 28 (div/divu) SHALL assert div_start for exactly one cycle and go to DIVW.
REQ-020 DECODE with any other legal ins SHALL go to EXEC.
REQ-021 EXEC with op in 35..42 (loads and stores) SHALL go to MEM.
REQ-022 EXEC with op in {16,43,44,45,48} SHALL assert pc_we and go to FETCH.
REQ-023 EXEC with op in {20,21,26} SHALL assert hilo_we and pc_we and go to FETCH.
REQ-024 EXEC with any other op SHALL go to WB.
REQ-025 MEM SHALL hold dmem_re=1 when op is 35..39 and dmem_we=1 when op is 40..42, for every cycle until dmem_ready=1; dmem_re and dmem_we SHALL never both be 1.
REQ-026 MEM on dmem_ready=1 SHALL go to WB for a load; for a store it SHALL assert pc_we and go to FETCH.
REQ-027 WB SHALL assert reg_we and pc_we for one cycle and go to FETCH.
REQ-028 DIVW SHALL hold until div_done=1; in that cycle it SHALL assert hilo_we and pc_we and go to FETCH.
REQ-029 EXC SHALL assert cp0_exc and pc_we for one cycle with cause held from DECODE, then go to FETCH.
REQ-030 All strobes SHALL be combinational from state, op and the current-cycle inputs; each SHALL be 0 in every state/condition not listed above.
REQ-031 retired SHALL increment by 1 on every pc_we cycle except EXC cycles.
REQ-032 retired SHALL wrap from 0xFFFFFFFF to 0 with no flag.
REQ-033 An imem_ready, dmem_ready or div_done pulse arriving outside its waiting state SHALL be ignored.

Reset
REQ-034 rst=1 SHALL immediately, without a clock edge, force state=FETCH, op=0, cause=0 and retired=0.
REQ-035 While rst=1, all strobe outputs SHALL be 0.
REQ-036 An access in flight when rst is asserted (MEM or DIVW) SHALL be abandoned; after release the FSM SHALL restart at FETCH.

Verification
REQ-037 Bench SHALL cover: reset, then imem_ready=1 with ins=0 (addu) -> states 0,1,2,4,0; reg_we=1 in WB; retired=1.
REQ-038 Bench SHALL cover: ins=35 (lw) with dmem_ready delayed 3 cycles -> dmem_re=1 for 4 cycles, then WB with reg_we=1; retired=1.
REQ-039 Bench SHALL cover: ins=27 (div) -> div_start=1 for 1 cycle; stay in state 5 until div_done; hilo_we=1 with pc_we=1.
REQ-040 Bench SHALL cover: ins=53 with teq_eq=1 -> EXC, cp0_exc=1, cause=13, retired unchanged; repeat with teq_eq=0 -> pc_we=1, retired increments.
REQ-041 Bench SHALL cover: ins=6'd60 -> cause=10; also ins=51 -> cause=8.
REQ-042 Bench SHALL cover: rst asserted mid-MEM with dmem_we=1 -> dmem_we drops immediately and state=0; also preload retired=0xFFFFFFFF and retire one -> 0.
